sub8_approx_pipe: RTL and testbench

Two-stage pipelined 8-bit approximate subtractor with valid/ready handshakes. It is the inverse-direction companion to the team's approximate 8-bit adders. The low APPROX_LSB bits use a borrow-free approximation that mirrors the truncated-carry low part of the adders. It also keeps on-line error statistics against the exact difference, so the datapath can be characterised in-system.

---
 rtl/sub8_approx_pipe_if.sv | 16 +
 rtl/sub8_approx_pipe.sv | 80 ++++++++
 tb/tb_sub8_approx_pipe.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sub8_approx_pipe_if.sv
// Operand/result handshake bundle for the approximate subtractor pipeline.
// The master side supplies operands and result back-pressure; the slave side is the pipeline.
interface sub8_approx_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] d;

    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, d);
    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, d);
endinterface

// File: rtl/sub8_approx_pipe.sv
// Two-stage approximate 8-bit subtractor: borrow-free XOR low part, exact high part,
// with in-system error statistics taken on delivered results.
module sub8_approx_pipe #(
    parameter int APPROX_LSB = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sub8_approx_pipe_if.slave     bus,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      err_cnt,
    output logic [7:0]            err_max
);
    localparam int STAGES = 2;

    // Masking the low bits before subtracting gives the high difference with zero borrow-in.
    localparam logic [8:0] HI_MASK = 9'h1FF << APPROX_LSB;
    localparam logic [7:0] LO_MASK = ~HI_MASK[7:0];

    logic [STAGES:1] vld_pipe;
    logic            s1_load, s2_load;
    logic [7:0]      s1_a, s1_b;
    logic [8:0]      s1_hi;
    logic [8:0]      d_q;
    logic [7:0]      s2_err;
    logic [7:0]      borrow_lo;
    logic            out_hs;

    assign s2_load      = !vld_pipe[2] || bus.out_ready;
    assign s1_load      = !vld_pipe[1] || s2_load;
    assign bus.in_ready = s1_load;
    assign bus.out_valid = vld_pipe[2];
    assign bus.d        = d_q;
    assign out_hs       = vld_pipe[2] && bus.out_ready;

    // Positions where the exact subtractor would have borrowed; each one costs 2 in the result.
    assign borrow_lo = ~s1_a & s1_b & LO_MASK;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_hi    <= '0;
            d_q      <= '0;
            s2_err   <= '0;
        end else begin
            if (s1_load) begin
                vld_pipe[1] <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_a  <= bus.a;
                    s1_b  <= bus.b;
                    s1_hi <= ({1'b0, bus.a} & HI_MASK) - ({1'b0, bus.b} & HI_MASK);
                end
            end
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    d_q    <= s1_hi | {1'b0, (s1_a ^ s1_b) & LO_MASK};
                    s2_err <= 8'(borrow_lo << 1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (stat_clr) begin
            err_cnt <= '0;
            err_max <= '0;
        end else if (out_hs) begin
            if (s2_err != 8'd0 && err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + 1'b1;
            if (s2_err > err_max)
                err_max <= s2_err;
        end
    end
endmodule

// File: tb/tb_sub8_approx_pipe.sv
// Bench for sub8_approx_pipe: directed vectors, stall/reset sequences, random handshakes
// against a scoreboard, and an exhaustive exact-mode stream on a K=0 instance.
module tb_sub8_approx_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_b, clr_a, clr_b;
    logic [15:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [7:0]  max_a, max_b, max_c;

    sub8_approx_pipe_if ifa ();
    sub8_approx_pipe_if ifb ();
    sub8_approx_pipe_if ifc ();

    // The narrow-counter instance mirrors every input of instance A.
    assign ifc.in_valid  = ifa.in_valid;
    assign ifc.a         = ifa.a;
    assign ifc.b         = ifa.b;
    assign ifc.out_ready = ifa.out_ready;

    sub8_approx_pipe #(.APPROX_LSB(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
        .stat_clr(clr_a), .err_cnt(cnt_a), .err_max(max_a));
    sub8_approx_pipe #(.APPROX_LSB(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(ifb.slave),
        .stat_clr(clr_b), .err_cnt(cnt_b), .err_max(max_b));
    sub8_approx_pipe #(.APPROX_LSB(4), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave),
        .stat_clr(clr_a), .err_cnt(cnt_c), .err_max(max_c));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: high part subtracted exactly on the truncated operands, low part XOR.
    function automatic logic [8:0] approx(input int k, input logic [7:0] a, input logic [7:0] b);
        int hi, lo;
        hi = ((int'(a) >> k) - (int'(b) >> k)) & ((1 << (9 - k)) - 1);
        lo = int'(a ^ b) & ((1 << k) - 1);
        return 9'(hi * (1 << k) + lo);
    endfunction

    function automatic int err_of(input logic [7:0] a, input logic [7:0] b, input logic [8:0] d);
        return (int'(d) - (int'(a) - int'(b))) & 511;
    endfunction

    typedef struct { logic [7:0] a; logic [7:0] b; } pair_t;
    pair_t q[$];
    int m_cnt = 0, m_cnt_c = 0, m_max = 0, outs_a = 0;

    initial forever @(posedge clk) cyc++;

    // Scoreboard for instances A and C, sampled mid-cycle where all handshake inputs are stable.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            m_cnt = 0; m_cnt_c = 0; m_max = 0;
            chk("rst_out_valid", ifa.out_valid, 0);
            chk("rst_d", ifa.d, 0);
            chk("rst_err_cnt", cnt_a, 0);
            chk("rst_err_max", max_a, 0);
        end else begin
            int er;
            pair_t p;
            chk("err_cnt", cnt_a, m_cnt);
            chk("err_max", max_a, m_max);
            chk("err_cnt_sat", cnt_c, m_cnt_c);
            chk("err_max_c", max_c, m_max);
            er = 0;
            if (ifa.out_valid && ifa.out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    p = q.pop_front();
                    chk("d", ifa.d, approx(4, p.a, p.b));
                    chk("d_c", ifc.d, approx(4, p.a, p.b));
                    er = err_of(p.a, p.b, approx(4, p.a, p.b));
                end
                outs_a++;
            end
            if (clr_a) begin
                m_cnt = 0; m_cnt_c = 0; m_max = 0;
            end else if (ifa.out_valid && ifa.out_ready) begin
                if (er != 0) begin
                    m_cnt++;
                    if (m_cnt_c < 15) m_cnt_c++;
                end
                if (er > m_max) m_max = er;
            end
            if (ifa.in_valid && ifa.in_ready) begin
                p.a = ifa.a; p.b = ifa.b;
                q.push_back(p);
            end
        end
    end

    // Exact-mode checker: outputs must follow the streamed pair index order.
    int nb = 0, b_first = 0, b_last = 0;
    logic b_done = 1'b0;
    initial forever begin
        @(negedge clk);
        if (rst_n_b && ifb.out_valid && ifb.out_ready) begin
            int ea, eb;
            ea = nb >> 8;
            eb = nb & 255;
            chk("d_exact", ifb.d, (ea - eb) & 511);
            if (nb == 0) b_first = cyc;
            b_last = cyc;
            nb++;
        end
    end

    typedef struct { logic [7:0] a; logic [7:0] b; logic [8:0] d; logic [7:0] err; } vec_t;
    vec_t  tbl[7];
    pair_t sv[5];

    initial begin
        int exp_cnt, exp_max, k, acc, outs0, iter;
        logic ok;

        tbl[0] = '{8'h10, 8'h01, 9'h011, 8'd2};
        tbl[1] = '{8'h00, 8'hFF, 9'h11F, 8'd30};
        tbl[2] = '{8'h20, 8'h10, 9'h010, 8'd0};
        tbl[3] = '{8'hFF, 8'h00, 9'h0FF, 8'd0};
        tbl[4] = '{8'h00, 8'h01, 9'h001, 8'd2};
        tbl[5] = '{8'h0F, 8'hF0, 9'h11F, 8'd0};
        tbl[6] = '{8'h37, 8'h5A, 9'h1ED, 8'd16};
        sv[0] = '{8'h10, 8'h01}; sv[1] = '{8'h00, 8'hFF}; sv[2] = '{8'h37, 8'h5A};
        sv[3] = '{8'h01, 8'h02}; sv[4] = '{8'hAB, 8'hCD};

        rst_n = 1'b0; rst_n_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.a = '0; ifa.b = '0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.a = '0; ifb.b = '0; ifb.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_b = 1'b1;
        chk("post_rst_in_ready", ifa.in_ready, 1);
        chk("post_rst_out_valid", ifa.out_valid, 0);
        chk("post_rst_d", ifa.d, 0);

        fork
            begin
                for (int i = 0; i < 65536; i++) begin
                    ifb.in_valid = 1'b1;
                    ifb.a = 8'(i >> 8);
                    ifb.b = 8'(i);
                    @(posedge clk);
                    #1;
                end
                ifb.in_valid = 1'b0;
                repeat (4) @(posedge clk);
                b_done = 1'b1;
            end
        join_none

        // Directed vectors, one at a time, with latency and statistics checks.
        exp_cnt = 0; exp_max = 0;
        for (int i = 0; i < 7; i++) begin
            ifa.a = tbl[i].a; ifa.b = tbl[i].b; ifa.in_valid = 1'b1;
            @(posedge clk); #1;
            ifa.in_valid = 1'b0;
            chk("vec_lat1_valid", ifa.out_valid, 0);
            @(posedge clk); #1;
            chk("vec_lat2_valid", ifa.out_valid, 1);
            chk("vec_d", ifa.d, tbl[i].d);
            @(posedge clk); #1;
            if (tbl[i].err != 0) exp_cnt++;
            if (int'(tbl[i].err) > exp_max) exp_max = tbl[i].err;
            chk("vec_err_cnt", cnt_a, exp_cnt);
            chk("vec_err_max", max_a, exp_max);
        end

        // Clear coincident with a handshake wins and the result is not counted.
        ifa.a = 8'h00; ifa.b = 8'hFF; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("clr_pre_valid", ifa.out_valid, 1);
        clr_a = 1'b1;
        @(posedge clk); #1;
        clr_a = 1'b0;
        chk("clr_err_cnt", cnt_a, 0);
        chk("clr_err_max", max_a, 0);
        chk("clr_err_cnt_c", cnt_c, 0);

        // Stall: only two results fit, output holds, then all five drain in order.
        outs0 = outs_a;
        ifa.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            ifa.a = sv[k].a; ifa.b = sv[k].b; ifa.in_valid = 1'b1;
            @(negedge clk);
            ok = ifa.in_ready;
            @(posedge clk); #1;
            if (ok) k++;
        end
        chk("stall_accepted", k, 2);
        chk("stall_in_ready", ifa.in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_valid", ifa.out_valid, 1);
            chk("stall_d_hold", ifa.d, approx(4, sv[0].a, sv[0].b));
            @(posedge clk); #1;
        end
        ifa.out_ready = 1'b1;
        iter = 0;
        while (k < 5 && iter < 20) begin
            ifa.a = sv[k].a; ifa.b = sv[k].b; ifa.in_valid = 1'b1;
            @(negedge clk);
            ok = ifa.in_ready;
            @(posedge clk); #1;
            if (ok) k++;
            iter++;
        end
        ifa.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("stall_outs", outs_a - outs0, 5);

        // Reset with two results buffered.
        ifa.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            ifa.a = sv[c + 1].a; ifa.b = sv[c + 1].b; ifa.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        ifa.in_valid = 1'b0;
        chk("full_in_ready", ifa.in_ready, 0);
        chk("full_out_valid", ifa.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", ifa.out_valid, 0);
        chk("midrst_d", ifa.d, 0);
        chk("midrst_err_cnt", cnt_a, 0);
        chk("midrst_err_max", max_a, 0);
        chk("midrst_err_cnt_c", cnt_c, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        chk("relrst_in_ready", ifa.in_ready, 1);
        ifa.a = 8'h20; ifa.b = 8'h10; ifa.in_valid = 1'b1;
        @(posedge clk); #1;
        ifa.in_valid = 1'b0;
        chk("relrst_lat1_valid", ifa.out_valid, 0);
        @(posedge clk); #1;
        chk("relrst_lat2_valid", ifa.out_valid, 1);
        chk("relrst_d", ifa.d, 9'h010);
        @(posedge clk); #1;

        // Random valid/ready/clear traffic; the scoreboard does the checking.
        acc = 0; iter = 0;
        while (acc < 10000 && iter < 60000) begin
            ifa.in_valid  = ($urandom_range(0, 3) != 0);
            ifa.a         = 8'($urandom);
            ifa.b         = 8'($urandom);
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            clr_a         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            if (ifa.in_valid && ifa.in_ready) acc++;
            @(posedge clk); #1;
            iter++;
        end
        chk("rand_accepted", acc, 10000);
        ifa.in_valid = 1'b0; clr_a = 1'b0; ifa.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_drained", q.size(), 0);

        iter = 0;
        while (!b_done && iter < 80000) begin
            @(posedge clk);
            iter++;
        end
        #1;
        chk("exact_done", b_done, 1);
        chk("exact_outs", nb, 65536);
        chk("exact_back_to_back", b_last - b_first, 65535);
        chk("exact_err_cnt", cnt_b, 0);
        chk("exact_err_max", max_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
